// File: rtl/adc_sampler.sv
// adc_sampler
// Parallel-ADC front end. Divides sys_clk down to the converter clock
// AD_clk, captures AD_digits_in a fixed number of sys_clk cycles after
// each AD_clk falling edge, averages 2^AVG_LOG2 captures and offers the
// result on a valid/ready port with a sticky overrun flag.
//
// Handshake (sample_vld / sample_rdy): a result is transferred on every
// sys_clk rising edge where sample_vld and sample_rdy are both 1. Once
// sample_vld is raised, sample_data holds until that transfer, except when
// a newer result overwrites it (which raises overrun). sample_vld never
// depends combinationally on sample_rdy.
module adc_sampler #(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 50,
   parameter int SAMPLE_DLY = 0,
   parameter int AVG_LOG2   = 0
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] AD_digits_in,
   output logic              AD_clk,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_vld,
   input  logic              sample_rdy,
   output logic              overrun,
   input  logic              clr_ovr
);

   // Divider and delay counters share one width. The delay counter only
   // needs to reach SAMPLE_DLY, which is always below CLK_DIV.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W = DATA_W + AVG_LOG2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DLY_LAST = DIV_W'(SAMPLE_DLY);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

   // Divider state
   logic              r_run;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              r_ad_clk;

   // Capture delay state
   logic              r_dly_act;
   logic [DIV_W-1:0]  r_dly_cnt;

   // Averaging state
   logic [ACC_W-1:0]  r_acc;
   logic [SMP_W-1:0]  r_smp_cnt;

   // Output state
   logic [DATA_W-1:0] r_sample_data;
   logic              r_sample_vld;
   logic              r_overrun;

   // Combinational helpers
   logic              w_div_wrap;
   logic              w_ad_fall;
   logic              w_capture;
   logic              w_last;
   logic [ACC_W-1:0]  w_sum;
   logic [DATA_W-1:0] w_avg;
   logic              w_new;
   logic              w_xfer;
   logic              w_ovr_set;

   // Divider wraps once the counter has run through a full half-period.
   assign w_div_wrap = r_run & (r_div_cnt == DIV_LAST);
   // Edge on which AD_clk is driven from 1 to 0: this arms the capture delay.
   assign w_ad_fall  = en & w_div_wrap & r_ad_clk;
   // Capture edge: the delay counter has counted SAMPLE_DLY+1 edges.
   assign w_capture  = en & r_dly_act & (r_dly_cnt == DLY_LAST);
   // Current capture closes an averaging group.
   assign w_last     = (r_smp_cnt == SMP_LAST);
   // Accumulator is sized so a full group of maximum codes cannot wrap.
   assign w_sum      = r_acc + ACC_W'(AD_digits_in);
   // Truncating divide by 2^AVG_LOG2.
   assign w_avg      = w_sum[ACC_W-1:AVG_LOG2];
   assign w_new      = w_capture & w_last;
   assign w_xfer     = r_sample_vld & sample_rdy;
   // A new result overwrites one that is still waiting and not leaving now.
   assign w_ovr_set  = w_new & r_sample_vld & ~sample_rdy;

   // AD_clk divider. The first enabled edge only starts the divider so that
   // AD_clk rises CLK_DIV edges after it; disabling parks AD_clk low.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run     <= 1'b0;
         r_div_cnt <= '0;
         r_ad_clk  <= 1'b0;
      end else if (!en) begin
         r_run     <= 1'b0;
         r_div_cnt <= '0;
         r_ad_clk  <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (r_run) begin
            if (w_div_wrap) begin
               r_div_cnt <= '0;
               r_ad_clk  <= ~r_ad_clk;
            end else begin
               r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
         end
      end
   end

   // Capture delay: armed on the AD_clk fall, fires once per AD_clk period.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly_act <= 1'b0;
         r_dly_cnt <= '0;
      end else if (!en) begin
         r_dly_act <= 1'b0;
         r_dly_cnt <= '0;
      end else if (w_ad_fall) begin
         r_dly_act <= 1'b1;
         r_dly_cnt <= '0;
      end else if (r_dly_act) begin
         if (r_dly_cnt == DLY_LAST) begin
            r_dly_act <= 1'b0;
         end else begin
            r_dly_cnt <= r_dly_cnt + DIV_W'(1);
         end
      end
   end

   // Accumulate captures; a partial group is discarded when en drops.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_smp_cnt <= '0;
      end else if (!en) begin
         r_acc     <= '0;
         r_smp_cnt <= '0;
      end else if (w_capture) begin
         if (w_last) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
         end else begin
            r_acc     <= w_sum;
            r_smp_cnt <= r_smp_cnt + SMP_W'(1);
         end
      end
   end

   // Result register and valid flag; independent of en so a held result
   // survives a stop and is still handed over.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_data <= '0;
         r_sample_vld  <= 1'b0;
      end else if (w_new) begin
         r_sample_data <= w_avg;
         r_sample_vld  <= 1'b1;
      end else if (w_xfer) begin
         r_sample_vld  <= 1'b0;
      end
   end

   // Sticky overrun; a set on the same edge as a clear wins.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
         r_overrun <= 1'b1;
      end else if (clr_ovr) begin
         r_overrun <= 1'b0;
      end
   end

   assign AD_clk      = r_ad_clk;
   assign sample_data = r_sample_data;
   assign sample_vld  = r_sample_vld;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler
// Three adc_sampler instances: default parameters, a 4-sample averaging
// configuration and a long-capture-delay configuration. Expected results are
// queued by the stimulus code and popped by per-instance monitors whenever a
// valid/ready transfer is about to happen.
module tb_adc_sampler;

  localparam int W = 8;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // default instance (CLK_DIV=50, SAMPLE_DLY=0, AVG_LOG2=0)
  logic         d_rst_n, d_en, d_rdy, d_clr;
  logic [W-1:0] d_din, d_data;
  logic         d_adclk, d_vld, d_ovr;
  // averaging instance (CLK_DIV=4, SAMPLE_DLY=1, AVG_LOG2=2)
  logic         a_rst_n, a_en, a_rdy, a_clr;
  logic [W-1:0] a_din, a_data;
  logic         a_adclk, a_vld, a_ovr;
  // delay instance (CLK_DIV=4, SAMPLE_DLY=3, AVG_LOG2=0)
  logic         s_rst_n, s_en, s_rdy, s_clr;
  logic [W-1:0] s_din, s_data;
  logic         s_adclk, s_vld, s_ovr;

  logic [W-1:0] d_exp_q[$];
  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] s_exp_q[$];

  adc_sampler #(.DATA_W(W), .CLK_DIV(50), .SAMPLE_DLY(0), .AVG_LOG2(0)) u_def (
    .sys_clk(clk), .rst_n(d_rst_n), .en(d_en), .AD_digits_in(d_din),
    .AD_clk(d_adclk), .sample_data(d_data), .sample_vld(d_vld),
    .sample_rdy(d_rdy), .overrun(d_ovr), .clr_ovr(d_clr)
  );

  adc_sampler #(.DATA_W(W), .CLK_DIV(4), .SAMPLE_DLY(1), .AVG_LOG2(2)) u_avg (
    .sys_clk(clk), .rst_n(a_rst_n), .en(a_en), .AD_digits_in(a_din),
    .AD_clk(a_adclk), .sample_data(a_data), .sample_vld(a_vld),
    .sample_rdy(a_rdy), .overrun(a_ovr), .clr_ovr(a_clr)
  );

  adc_sampler #(.DATA_W(W), .CLK_DIV(4), .SAMPLE_DLY(3), .AVG_LOG2(0)) u_dly (
    .sys_clk(clk), .rst_n(s_rst_n), .en(s_en), .AD_digits_in(s_din),
    .AD_clk(s_adclk), .sample_data(s_data), .sample_vld(s_vld),
    .sample_rdy(s_rdy), .overrun(s_ovr), .clr_ovr(s_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: sample on the falling edge, a transfer follows on
  // the next rising edge
  always @(negedge clk) begin
    if (d_rst_n && d_vld && d_rdy) begin
      if (d_exp_q.size() == 0) check("def_unexpected_result", 32'(d_data), 32'hFFFF_FFFF);
      else check("def_result", 32'(d_data), 32'(d_exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (a_rst_n && a_vld && a_rdy) begin
      if (a_exp_q.size() == 0) check("avg_unexpected_result", 32'(a_data), 32'hFFFF_FFFF);
      else check("avg_result", 32'(a_data), 32'(a_exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (s_rst_n && s_vld && s_rdy) begin
      if (s_exp_q.size() == 0) check("dly_unexpected_result", 32'(s_data), 32'hFFFF_FFFF);
      else check("dly_result", 32'(s_data), 32'(s_exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // wait for the next AD_clk fall of u_avg, then present the next code
  task automatic avg_capture(input logic [W-1:0] v);
    logic prev;
    bit   found;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      prev = a_adclk;
      @(posedge clk);
      #1;
      if (prev && !a_adclk) found = 1'b1;
    end
    check("avg_fall_seen", 32'(found), 32'd1);
    a_din = v;
  endtask

  task automatic avg_group(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) avg_capture(v);
  endtask

  task automatic check_reset_outputs(input string tag, input logic adclk, input logic [W-1:0] data,
                                     input logic vld, input logic ovr);
    check({tag, "_adclk"}, 32'(adclk), 32'd0);
    check({tag, "_data"},  32'(data),  32'd0);
    check({tag, "_vld"},   32'(vld),   32'd0);
    check({tag, "_ovr"},   32'(ovr),   32'd0);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    d_rst_n = 0; d_en = 0; d_rdy = 0; d_clr = 0; d_din = '0;
    a_rst_n = 0; a_en = 0; a_rdy = 0; a_clr = 0; a_din = '0;
    s_rst_n = 0; s_en = 0; s_rdy = 0; s_clr = 0; s_din = '0;
    tick(3);
    check_reset_outputs("def_reset", d_adclk, d_data, d_vld, d_ovr);
    check_reset_outputs("avg_reset", a_adclk, a_data, a_vld, a_ovr);
    check_reset_outputs("dly_reset", s_adclk, s_data, s_vld, s_ovr);
    d_rst_n = 1; a_rst_n = 1; s_rst_n = 1;
    tick(2);

    // ---- defaults: constant 0x5A, free-running consumer ----
    d_din = 8'h5A;
    d_rdy = 1;
    d_exp_q.push_back(8'h5A);
    d_exp_q.push_back(8'h5A);
    d_en = 1;
    for (int k = 0; k <= 205; k++) begin
      tick(1);
      check($sformatf("def_adclk_e%0d", k), 32'(d_adclk), 32'((k / 50) % 2));
      check($sformatf("def_vld_e%0d", k), 32'(d_vld), 32'((k == 101) || (k == 201)));
    end
    check("def_ovr", 32'(d_ovr), 32'd0);
    d_en = 0;
    tick(2);
    check("def_adclk_stopped", 32'(d_adclk), 32'd0);

    // ---- averaging: 10,11,12,14 -> 11 ; 4 x 255 -> 255 ----
    a_rdy = 1;
    a_exp_q.push_back(8'd11);
    a_exp_q.push_back(8'd255);
    a_en = 1;
    avg_capture(8'd10);
    avg_capture(8'd11);
    avg_capture(8'd12);
    avg_capture(8'd14);
    avg_group(8'd255, 4);
    tick(4);
    check("avg_vld_idle", 32'(a_vld), 32'd0);

    // ---- overrun: 0x11 then 0x22 unconsumed ----
    a_rdy = 0;
    avg_group(8'h11, 4);
    avg_group(8'h22, 4);
    tick(2);
    check("ovr_vld_held", 32'(a_vld), 32'd1);
    check("ovr_data_new", 32'(a_data), 32'h22);
    check("ovr_flag_set", 32'(a_ovr), 32'd1);
    a_clr = 1;
    tick(1);
    a_clr = 0;
    tick(1);
    check("ovr_flag_cleared", 32'(a_ovr), 32'd0);
    a_exp_q.push_back(8'h22);
    a_rdy = 1;
    tick(2);
    a_rdy = 0;
    check("ovr_vld_drained", 32'(a_vld), 32'd0);

    // ---- clr_ovr on the same edge as a new overrun: set wins ----
    avg_group(8'h33, 4);
    avg_group(8'h44, 3);
    avg_capture(8'h44);
    tick(1);
    a_clr = 1;
    tick(1);
    a_clr = 0;
    check("ovr_set_beats_clr", 32'(a_ovr), 32'd1);
    check("ovr_set_beats_clr_data", 32'(a_data), 32'h44);
    a_exp_q.push_back(8'h44);
    a_rdy = 1;
    tick(2);
    a_clr = 1;
    tick(1);
    a_clr = 0;
    a_rdy = 0;
    check("ovr_final_clear", 32'(a_ovr), 32'd0);
    check("ovr_final_vld", 32'(a_vld), 32'd0);

    // ---- transfer and new result on the same edge ----
    avg_group(8'h55, 4);
    a_exp_q.push_back(8'h55);
    a_exp_q.push_back(8'h66);
    avg_group(8'h66, 3);
    avg_capture(8'h66);
    tick(1);
    a_rdy = 1;
    tick(1);
    check("same_edge_vld", 32'(a_vld), 32'd1);
    check("same_edge_data", 32'(a_data), 32'h66);
    check("same_edge_ovr", 32'(a_ovr), 32'd0);
    tick(2);
    check("same_edge_vld_drop", 32'(a_vld), 32'd0);

    // ---- en drop mid-average with a held result ----
    a_rdy = 0;
    avg_group(8'h70, 4);
    tick(2);
    check("hold_vld", 32'(a_vld), 32'd1);
    check("hold_data", 32'(a_data), 32'h70);
    avg_group(8'hF0, 2);
    for (int k = 0; k < 12 && !a_adclk; k++) tick(1);
    check("stop_adclk_high_before", 32'(a_adclk), 32'd1);
    a_en = 0;
    tick(1);
    check("stop_adclk_low", 32'(a_adclk), 32'd0);
    tick(6);
    check("stop_vld_kept", 32'(a_vld), 32'd1);
    check("stop_data_kept", 32'(a_data), 32'h70);
    a_exp_q.push_back(8'h70);
    a_exp_q.push_back(8'h26);   // (0x20+0x24+0x28+0x2C)>>2 = 152>>2 = 38
    a_rdy = 1;
    tick(2);
    a_en = 1;
    avg_capture(8'h20);
    avg_capture(8'h24);
    avg_capture(8'h28);
    avg_capture(8'h2C);
    tick(4);
    check("restart_vld_idle", 32'(a_vld), 32'd0);
    a_en = 0;

    // ---- SAMPLE_DLY=3, CLK_DIV=4: capture 4 edges after the fall ----
    s_rdy = 1;
    s_exp_q.push_back(8'hB2);
    s_en = 1;
    for (int k = 0; k <= 13; k++) begin
      tick(1);
      check($sformatf("dly_adclk_e%0d", k), 32'(s_adclk), 32'((k / 4) % 2));
      check($sformatf("dly_vld_e%0d", k), 32'(s_vld), 32'(k == 12));
      if (k == 8)  s_din = 8'hA1;   // sampled by edge 9..11
      if (k == 11) s_din = 8'hB2;   // sampled by edge 12 only
      if (k == 12) s_din = 8'hC3;   // sampled by edge 13 onward
    end
    s_rdy = 0;
    tick(16);                       // now just after edge 29
    check("dly_pre_rst_adclk", 32'(s_adclk), 32'd1);
    check("dly_pre_rst_vld", 32'(s_vld), 32'd1);
    check("dly_pre_rst_ovr", 32'(s_ovr), 32'd1);
    check("dly_pre_rst_data", 32'(s_data), 32'hC3);
    #1;
    s_rst_n = 0;
    #1;
    check_reset_outputs("dly_async_rst", s_adclk, s_data, s_vld, s_ovr);
    s_en = 0;
    tick(2);
    s_rst_n = 1;
    tick(2);

    check("def_queue_empty", 32'(d_exp_q.size()), 32'd0);
    check("avg_queue_empty", 32'(a_exp_q.size()), 32'd0);
    check("dly_queue_empty", 32'(s_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sampler.md
# adc_sampler

Parametrised parallel-ADC front end: generates the converter clock from `sys_clk`, captures the converter's parallel output a programmable delay after each falling edge of that clock, averages 2^AVG_LOG2 captures, and presents the result on a valid/ready interface with sticky overrun detection. It replaces the fixed 8-bit, 1 MHz, free-running capture path between the external ADC pins and downstream DSP/buffer logic.

## Interface
- `DATA_W`, 8, ADC data width (1..16)
- `CLK_DIV`, 50, `AD_clk` half-period in `sys_clk` cycles; ≥2 (50 → 1 MHz at 100 MHz)
- `SAMPLE_DLY`, 0, extra `sys_clk` cycles between the `AD_clk` fall and capture; 0..CLK_DIV-2
- `AVG_LOG2`, 0, log2 of the number of captures averaged per result; 0..4
- `sys_clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run enable; low stops `AD_clk` and clears the averaging state
- `AD_digits_in`  in  DATA_W  ADC parallel data, valid while `AD_clk` is low
- `AD_clk`  out  DATA_W=n/a, 1  converter clock, registered
- `sample_data`  out  DATA_W  averaged result
- `sample_vld`  out  1  result valid
- `sample_rdy`  in  1  consumer ready
- `overrun`  out  1  sticky: an unconsumed result was overwritten
- `clr_ovr`  in  1  single-cycle clear of `overrun`

## Operation
- Reset values: `AD_clk`=0, `sample_data`=0, `sample_vld`=0, `overrun`=0; divider, delay, and sample counters and the accumulator are 0.
- Divider: while `en`=1, `div_cnt` counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and `AD_clk` toggles. While `en`=0, `div_cnt`←0 and `AD_clk`←0.
- Capture: the edge that drives `AD_clk` 1→0 arms the delay counter. `AD_digits_in` is captured on the (SAMPLE_DLY+1)-th following edge. Only one capture occurs per `AD_clk` period.
- Averaging: the accumulator is DATA_W+AVG_LOG2 bits wide, and `smp_cnt` counts 0..2^AVG_LOG2-1.
  - On non-final captures: `acc`←`acc`+din and `smp_cnt`+1.
  - On the final capture, on the same edge: `sample_data`←(`acc`+din)>>AVG_LOG2 (truncating), `acc`←0, `smp_cnt`←0, `sample_vld`←1.
- Handshake: a transfer occurs on an edge where `sample_vld`=1 and `sample_rdy`=1.
  - Transfer with no new result: `sample_vld`←0.
  - New result with no transfer while `sample_vld`=1: data is overwritten, `sample_vld` stays 1, and `overrun`←1.
  - Transfer and new result on the same edge: the new data is loaded, `sample_vld` stays 1, and `overrun` is unchanged.
  - `sample_data` is stable while `sample_vld`=1, except on an overrun.
- `overrun`: cleared by `clr_ovr`. If set and clear occur on the same edge, set wins.
- `en` falling mid-average: `acc`, `smp_cnt`, and a pending delay are cleared, so a partial average is discarded. A result already held (`sample_vld`=1) is kept until transferred. `sample_rdy` handling is independent of `en`.
- Reset mid-operation: asynchronous; all state returns to reset values immediately.

## Timing
- Edge 0 is the first edge sampling `en`=1. `AD_clk` rises at edge CLK_DIV and falls at edge 2·CLK_DIV.
- `AD_clk` period = 2·CLK_DIV cycles with a 50 % duty cycle.
- First capture occurs at edge 2·CLK_DIV+SAMPLE_DLY+1.
- First `sample_vld` occurs at edge 2^AVG_LOG2·2·CLK_DIV+SAMPLE_DLY+1. Subsequent results follow every 2^(AVG_LOG2+1)·CLK_DIV cycles.
- Capture-to-`sample_vld` latency is 0 cycles (same edge). `sample_vld` can drop at the earliest one edge after rising.
- The capture always falls inside the `AD_clk`-low half, because SAMPLE_DLY ≤ CLK_DIV-2.

## Test plan
- Defaults, `en`=1, `sample_rdy`=1, input constant 0x5A: `AD_clk` rises at edge 50 with a 100-cycle period; `sample_vld` is a 1-cycle pulse every 100 cycles, starting at edge 101, with `sample_data`=0x5A; `overrun`=0.
- AVG_LOG2=2, inputs 10, 11, 12, 14 on successive captures: a single `sample_vld` with `sample_data`=11 (47>>2). The next group of 255, 255, 255, 255 → 255 with no wrap.
- `sample_rdy`=0 across two results 0x11 then 0x22: `sample_vld` stays high, `sample_data`=0x22, `overrun`=1. `clr_ovr` pulse → `overrun`=0. `clr_ovr` on the same edge as a new overrun → `overrun` stays 1.
- `sample_rdy` is asserted on exactly the edge a new result arrives: old data is transferred, the new data is loaded, `sample_vld` stays 1, and `overrun`=0.
- AVG_LOG2=2: drop `en` after 2 captures, then restart. `AD_clk`=0 one edge later; the next result averages 4 fresh captures only; a held result survives `en`=0.
- SAMPLE_DLY=3, CLK_DIV=4: the capture edge is 4 edges after the `AD_clk` fall. Assert `rst_n` low mid-period: all outputs are 0 immediately.
